// File: rtl/sram_pkg.sv
// Shared SRAM constants and OBI bundle types for the SRAM subsystem.
package sram_pkg;

  localparam logic [31:0] SRAM_BASE_ADDR   = 32'h8000_0000;
  localparam int unsigned SRAM_NUM_BLOCKS  = 4;
  localparam int unsigned SRAM_BLOCK_BYTES = 2048;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_rsp_t;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order owner-ID FIFO; push and pop may coincide, even when full.
module sram_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(DEPTH));
  assign count_o = r_count;
  assign dout_o  = r_mem[r_rd_ptr];

  assign w_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is legal then.
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/sram_d_arbiter.sv
// Round-robin two-master OBI arbiter onto the SRAM data port, with in-order response routing.
module sram_d_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,

  output logic        sram_d_req_o,
  input  logic        sram_d_gnt_i,
  output logic [31:0] sram_d_addr_o,
  output logic        sram_d_we_o,
  output logic [3:0]  sram_d_be_o,
  output logic [31:0] sram_d_wdata_o,
  input  logic        sram_d_rvalid_i,
  input  logic [31:0] sram_d_rdata_i,

  output logic        resp_orphan_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  obi_req_t      w_m0;
  obi_req_t      w_m1;
  obi_req_t      w_fwd;
  obi_rsp_t      w_down;
  owner_e        w_sel;
  owner_e        w_head;
  owner_e        r_last;
  logic [0:0]    w_head_raw;
  logic          w_fifo_full;
  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;

  assign w_m0   = '{req: m0_req_i, addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  assign w_m1   = '{req: m1_req_i, addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
  assign w_down = '{gnt: sram_d_gnt_i, rvalid: sram_d_rvalid_i, rdata: sram_d_rdata_i};

  // On a tie the master that did not win the last accepted handshake goes next.
  always_comb begin
    w_sel = OWNER_M0;
    if (m1_req_i && !m0_req_i) begin
      w_sel = OWNER_M1;
    end else if (m0_req_i && m1_req_i) begin
      w_sel = (r_last == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    end
  end

  assign w_fwd = (w_sel == OWNER_M1) ? w_m1 : w_m0;

  // A response in this cycle pops a slot, so a full FIFO does not block a new request.
  assign w_fifo_full = (w_count == CW'(MAX_OUTSTANDING)) & ~w_down.rvalid;

  assign sram_d_req_o   = w_fwd.req & ~w_fifo_full;
  assign sram_d_addr_o  = w_fwd.addr;
  assign sram_d_we_o    = w_fwd.we;
  assign sram_d_be_o    = w_fwd.be;
  assign sram_d_wdata_o = w_fwd.wdata;

  assign w_accept = sram_d_req_o & w_down.gnt;
  assign m0_gnt_o = w_accept & (w_sel == OWNER_M0);
  assign m1_gnt_o = w_accept & (w_sel == OWNER_M1);

  assign w_pop  = w_down.rvalid & ~w_empty;
  assign w_push = w_accept & (~w_full | w_pop);
  assign w_head = owner_e'(w_head_raw);

  assign m0_rvalid_o   = w_pop & (w_head == OWNER_M0);
  assign m1_rvalid_o   = w_pop & (w_head == OWNER_M1);
  assign m0_rdata_o    = w_down.rdata;
  assign m1_rdata_o    = w_down.rdata;
  assign resp_orphan_o = w_down.rvalid & w_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= OWNER_M1;
    end else if (w_accept) begin
      r_last <= w_sel;
    end
  end

  sram_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_sel),
    .dout_o  (w_head_raw),
    .empty_o (w_empty),
    .full_o  (w_full),
    .count_o (w_count)
  );

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Bench for sram_d_arbiter: vector table, directed corner sequences and random traffic vs. a queue model.
module tb_sram_d_arbiter;

  localparam int unsigned MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        sram_d_req_o, sram_d_gnt_i, sram_d_we_o, sram_d_rvalid_i, resp_orphan_o;
  logic [31:0] sram_d_addr_o, sram_d_wdata_o, sram_d_rdata_i;
  logic [3:0]  sram_d_be_o;

  always #5 clk = ~clk;

  sram_d_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .sram_d_req_o(sram_d_req_o), .sram_d_gnt_i(sram_d_gnt_i), .sram_d_addr_o(sram_d_addr_o),
    .sram_d_we_o(sram_d_we_o), .sram_d_be_o(sram_d_be_o), .sram_d_wdata_o(sram_d_wdata_o),
    .sram_d_rvalid_i(sram_d_rvalid_i), .sram_d_rdata_i(sram_d_rdata_i),
    .resp_orphan_o(resp_orphan_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of outstanding owners (0 = m0, 1 = m1) plus last winner.
  int          mq[$];
  bit          m_last;
  bit          e_acc, e_sel, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;

  // Downstream SRAM wrapper model: grants at once, responds one cycle after accept.
  bit          auto_rsp;
  bit          pend_v;
  logic [31:0] pend_d;
  logic [31:0] mem [logic [31:0]];

  logic obs_g0, obs_g1, obs_req, obs_rv0, obs_rv1, obs_orph;
  logic [31:0] obs_rd0, obs_rd1;

  typedef struct {
    bit       r0, r1, gnt, rv;
    bit [5:0] exp;  // {g0, g1, req, rv0, rv1, orphan}
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m0_req_i = 0; m1_req_i = 0; m0_we_i = 0; m1_we_i = 0;
    m0_addr_i = 32'h8000_0000; m1_addr_i = 32'h8000_0800;
    m0_wdata_i = 32'h0; m1_wdata_i = 32'h0; m0_be_i = 4'hF; m1_be_i = 4'hF;
    sram_d_gnt_i = 0; sram_d_rvalid_i = 0; sram_d_rdata_i = 32'h0;
  endtask

  task automatic model_check();
    bit full, req, sel, rv0, rv1, orph;
    full = (mq.size() == MAX) && !sram_d_rvalid_i;
    req  = (m0_req_i || m1_req_i) && !full;
    if (m0_req_i && m1_req_i) sel = !m_last;
    else                      sel = m1_req_i;
    rv0  = sram_d_rvalid_i && mq.size() > 0 && mq[0] == 0;
    rv1  = sram_d_rvalid_i && mq.size() > 0 && mq[0] == 1;
    orph = sram_d_rvalid_i && mq.size() == 0;
    e_acc   = req && sram_d_gnt_i;
    e_sel   = sel;
    e_addr  = sel ? m1_addr_i  : m0_addr_i;
    e_we    = sel ? m1_we_i    : m0_we_i;
    e_be    = sel ? m1_be_i    : m0_be_i;
    e_wdata = sel ? m1_wdata_i : m0_wdata_i;
    check("model_ctrl", {m0_gnt_o, m1_gnt_o, sram_d_req_o, m0_rvalid_o, m1_rvalid_o, resp_orphan_o},
          {e_acc && !sel, e_acc && sel, req, rv0, rv1, orph});
    check("model_fwd", {sram_d_addr_o, sram_d_we_o, sram_d_be_o, sram_d_wdata_o},
          {e_addr, e_we, e_be, e_wdata});
    check("model_rdata", {m0_rdata_o, m1_rdata_o}, {sram_d_rdata_i, sram_d_rdata_i});
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model at posedge.
  task automatic step();
    logic [31:0] cur;
    if (auto_rsp) begin
      sram_d_gnt_i    = 1;
      sram_d_rvalid_i = pend_v;
      sram_d_rdata_i  = pend_d;
    end
    @(negedge clk);
    obs_g0 = m0_gnt_o; obs_g1 = m1_gnt_o; obs_req = sram_d_req_o;
    obs_rv0 = m0_rvalid_o; obs_rv1 = m1_rvalid_o; obs_orph = resp_orphan_o;
    obs_rd0 = m0_rdata_o; obs_rd1 = m1_rdata_o;
    model_check();
    @(posedge clk);
    if (sram_d_rvalid_i && mq.size() > 0) void'(mq.pop_front());
    if (e_acc) begin
      mq.push_back(int'(e_sel));
      m_last = e_sel;
    end
    if (auto_rsp) begin
      pend_v = e_acc;
      if (e_acc) begin
        cur = mem.exists(e_addr) ? mem[e_addr] : 32'h0;
        if (e_we) begin
          for (int b = 0; b < 4; b++) if (e_be[b]) cur[8*b +: 8] = e_wdata[8*b +: 8];
          mem[e_addr] = cur;
          pend_d = 32'h0;
        end else begin
          pend_d = cur;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    auto_rsp = 0; pend_v = 0; pend_d = 32'h0;
    mq.delete(); m_last = 1;
    #1;
    check("rst_outputs", {m0_gnt_o, m1_gnt_o, sram_d_req_o, m0_rvalid_o, m1_rvalid_o, resp_orphan_o}, 6'b0);
    sram_d_rvalid_i = 1;
    #1;
    check("rst_orphan", {m0_rvalid_o, m1_rvalid_o, resp_orphan_o}, 3'b001);
    sram_d_rvalid_i = 0;
    @(posedge clk);
    #3 rst = 0;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[15];
  int   order_ok;
  int   rv0_cnt, rv1_cnt;
  bit   prev_g0, prev_g1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 0, 1, 0, 6'b000000};
    vecs[1]  = '{0, 0, 1, 1, 6'b000001};
    vecs[2]  = '{1, 1, 1, 0, 6'b101000};
    vecs[3]  = '{1, 1, 1, 1, 6'b011100};
    vecs[4]  = '{1, 1, 1, 1, 6'b101010};
    vecs[5]  = '{0, 1, 1, 0, 6'b011000};
    vecs[6]  = '{1, 1, 1, 0, 6'b000000};
    vecs[7]  = '{1, 1, 1, 1, 6'b101100};
    vecs[8]  = '{1, 0, 1, 0, 6'b000000};
    vecs[9]  = '{0, 0, 1, 1, 6'b000010};
    vecs[10] = '{0, 0, 1, 1, 6'b000100};
    vecs[11] = '{0, 0, 1, 1, 6'b000001};
    vecs[12] = '{1, 0, 0, 0, 6'b001000};
    vecs[13] = '{0, 1, 1, 0, 6'b011000};
    vecs[14] = '{1, 1, 1, 1, 6'b101010};

    do_reset();

    // Vector table: arbitration, backpressure and push/pop-when-full.
    for (int i = 0; i < 15; i++) begin
      m0_req_i = vecs[i].r0; m1_req_i = vecs[i].r1;
      sram_d_gnt_i = vecs[i].gnt; sram_d_rvalid_i = vecs[i].rv;
      sram_d_rdata_i = $urandom;
      step();
      check($sformatf("vec%0d", i), {obs_g0, obs_g1, obs_req, obs_rv0, obs_rv1, obs_orph}, vecs[i].exp);
    end

    // m0 alone against the wrapper model: write then read back.
    do_reset();
    auto_rsp = 1;
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h8000_0010; m0_wdata_i = 32'hCAFE_F00D; m0_be_i = 4'hF;
    step();
    check("wr_gnt", obs_g0, 1'b1);
    m0_we_i = 0;
    step();
    check("rd_gnt_wr_rsp", {obs_g0, obs_rv0, obs_rv1}, 3'b110);
    m0_req_i = 0;
    step();
    check("rd_rsp", {obs_rv0, obs_rv1, obs_rd0}, {1'b1, 1'b0, 32'hCAFE_F00D});

    // Both masters request continuously for 6 cycles.
    do_reset();
    auto_rsp = 1;
    m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h8000_0000; m1_addr_i = 32'h8000_0800;
    order_ok = 0; rv0_cnt = 0; rv1_cnt = 0; prev_g0 = 0; prev_g1 = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin m0_req_i = 0; m1_req_i = 0; end
      step();
      if (i < 6 && obs_g0 == (i % 2 == 0) && obs_g1 == (i % 2 == 1)) order_ok++;
      if (obs_rv0) rv0_cnt++;
      if (obs_rv1) rv1_cnt++;
      check($sformatf("rsp_follows_gnt%0d", i), {obs_rv0, obs_rv1}, {prev_g0, prev_g1});
      prev_g0 = obs_g0; prev_g1 = obs_g1;
    end
    check("grant_order", order_ok, 6);
    check("rv_counts", {rv0_cnt[7:0], rv1_cnt[7:0]}, {8'd3, 8'd3});

    // Mixed owners: m1 then m0 outstanding, delayed responses.
    do_reset();
    sram_d_gnt_i = 1;
    m1_req_i = 1; step();
    m1_req_i = 0; m0_req_i = 1; step();
    m0_req_i = 0; step();
    sram_d_rvalid_i = 1; sram_d_rdata_i = 32'h11; step();
    check("mixed_first", {obs_rv0, obs_rv1, obs_rd1}, {1'b0, 1'b1, 32'h11});
    sram_d_rdata_i = 32'h22; step();
    check("mixed_second", {obs_rv0, obs_rv1, obs_rd0}, {1'b1, 1'b0, 32'h22});
    step();
    check("stray", {obs_rv0, obs_rv1, obs_orph}, 3'b001);
    sram_d_rvalid_i = 0; step();
    check("stray_one_cycle", obs_orph, 1'b0);

    // Asynchronous reset with two transactions in flight.
    do_reset();
    sram_d_gnt_i = 1;
    m0_req_i = 1; step();
    m0_req_i = 0; m1_req_i = 1; step();
    m1_req_i = 0;
    #2 rst = 1;
    #1 sram_d_rvalid_i = 1;
    #1;
    check("midrst_empty", {m0_rvalid_o, m1_rvalid_o, resp_orphan_o}, 3'b001);
    mq.delete(); m_last = 1;
    rst = 0;
    step();
    check("post_rst_orphan", {obs_rv0, obs_rv1, obs_orph}, 3'b001);
    sram_d_rvalid_i = 0; m0_req_i = 1; m1_req_i = 1;
    step();
    check("post_rst_tie", {obs_g0, obs_g1}, 2'b10);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      m0_req_i = $urandom_range(0, 1); m1_req_i = $urandom_range(0, 1);
      m0_we_i = $urandom_range(0, 1);  m1_we_i = $urandom_range(0, 1);
      m0_addr_i = $urandom; m1_addr_i = $urandom;
      m0_be_i = 4'($urandom); m1_be_i = 4'($urandom);
      m0_wdata_i = $urandom; m1_wdata_i = $urandom;
      sram_d_gnt_i = ($urandom_range(0, 3) != 0);
      sram_d_rvalid_i = ($urandom_range(0, 2) == 0);
      sram_d_rdata_i = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_d_arbiter.md
# sram_d_arbiter

Two-master OBI arbiter that merges the core data port (m0) and the host/debug bridge port (m1) onto the single `sram_d` port of the SRAM wrapper. It performs round-robin arbitration on requests and forwards at most one request per cycle. It also tracks the owner of every outstanding transaction in an in-order ID FIFO, so each `rvalid`/`rdata` returns to the master that issued it. It sits directly upstream of the SRAM wrapper's data port; the wrapper grants immediately and responds one cycle later, but the arbiter tolerates any in-order downstream latency up to `MAX_OUTSTANDING`.

## Interface
- `MAX_OUTSTANDING`, 2 — depth of the owner FIFO; maximum number of accepted requests awaiting `rvalid`. Must be ≥1.
- `clk_i`  in  1 — clock.
- `rst_i`  in  1 — asynchronous, active-high reset.
- `m0_req_i`, `m1_req_i`  in  1 — master request.
- `m0_gnt_o`, `m1_gnt_o`  out  1 — master grant (combinational).
- `m0_addr_i`, `m1_addr_i`  in  32 — byte address.
- `m0_we_i`, `m1_we_i`  in  1 — write enable.
- `m0_be_i`, `m1_be_i`  in  4 — byte enables.
- `m0_wdata_i`, `m1_wdata_i`  in  32 — write data.
- `m0_rvalid_o`, `m1_rvalid_o`  out  1 — response valid, routed by owner.
- `m0_rdata_o`, `m1_rdata_o`  out  32 — response data. Both carry `sram_d_rdata_i` unconditionally.
- `sram_d_req_o`  out  1; `sram_d_gnt_i`  in  1; `sram_d_addr_o`  out  32; `sram_d_we_o`  out  1; `sram_d_be_o`  out  4; `sram_d_wdata_o`  out  32; `sram_d_rvalid_i`  in  1; `sram_d_rdata_i`  in  32 — downstream OBI port to the SRAM wrapper.
- `resp_orphan_o`  out  1 — single-cycle pulse when `sram_d_rvalid_i` arrives with the owner FIFO empty.

## Operation
- **Arbitration.** `sel` is combinational.
  - Only one master requesting: `sel` = that master.
  - Both masters requesting: `sel` = the master that did not win the most recent accepted handshake (`last_q`, reset 1, so m0 wins the first tie).
- **Request forwarding.**
  - `sram_d_req_o` = (`m0_req_i` | `m1_req_i`) & !`fifo_full`.
  - Address, we, be and wdata are muxed from `sel`. When neither master requests, they mirror m0.
- **Grant.**
  - `mX_gnt_o` = `sram_d_gnt_i` & `sram_d_req_o` & (`sel`==X).
  - The unselected master sees `gnt`=0 and must hold its request stable.
- **Accept** = `sram_d_req_o` & `sram_d_gnt_i`. On accept:
  - push `sel` into the owner FIFO;
  - set `last_q` <= `sel`.
- **Response.** On `sram_d_rvalid_i`:
  - if the FIFO is non-empty: pop the head and drive `mX_rvalid_o`=1 only for X = head;
  - if the FIFO is empty: both `rvalid` outputs stay 0 and `resp_orphan_o`=1 for that cycle.
- **Simultaneous push and pop.** Allowed in the same cycle, including when the FIFO is full, because the pop frees a slot combinationally. The count is unchanged.
  - `fifo_full` for request gating is defined as count==`MAX_OUTSTANDING` & !`sram_d_rvalid_i`.
- **Ordering.** Responses are assumed in-order, which the SRAM wrapper guarantees.
- **Reset.**
  - Async assert clears FIFO pointers, count and `last_q`=1.
  - Outstanding transactions at reset are discarded. Any later stray `rvalid` produces `resp_orphan_o`.
- **Output reset values.**
  - `mX_gnt_o`, `sram_d_req_o`: follow their inputs.
  - `mX_rvalid_o`: 0.
  - `resp_orphan_o`: follows `sram_d_rvalid_i`, since the FIFO is empty.

## Timing
- Request path is combinational: `mX_req_i` → `sram_d_req_o`/`gnt`, zero cycles.
- With the SRAM wrapper downstream (gnt = req, rvalid one cycle after accept), throughput is one transaction per cycle back-to-back. The owner FIFO holds at most 1 entry in steady state.
- Response path is combinational from `sram_d_rvalid_i` and the FIFO head to `mX_rvalid_o`.
- FIFO pointers wrap modulo `MAX_OUTSTANDING`. The count width is `$clog2(MAX_OUTSTANDING+1)`.

## Structure
- `sram_pkg` holds the shared SRAM constants (base address, block count, block size) and the OBI typedefs `obi_req_t` (req, addr, we, be, wdata) and `obi_rsp_t` (gnt, rvalid, rdata). `sram_d_arbiter` uses these internally for muxing.
- Sub-module `sram_arb_id_fifo`:
  - parameters: depth and width (width 1 here);
  - ports: push, pop, din, dout, empty, full, count;
  - async active-high reset.
- Arbitration and routing logic live in `sram_d_arbiter`.

## Test plan
- **m0 alone, with the SRAM wrapper model.**
  - Stimulus: m0 writes 0xCAFE_F00D to 0x8000_0010, then reads it back.
  - Required: `m0_gnt_o`=1 in the request cycle; `m0_rvalid_o`=1 on the next cycle with rdata 0xCAFE_F00D; `m1_rvalid_o` stays 0.
- **Both masters request continuously for 6 cycles** (m0 address 0x8000_0000, m1 address 0x8000_0800).
  - Required grant order: m0, m1, m0, m1, m0, m1.
  - Each master receives exactly 3 `rvalid`s, each one cycle after its grant.
- **Backpressure.**
  - Stimulus: `MAX_OUTSTANDING`=2; a downstream model holds `rvalid` low.
  - Required: two accepts, then `sram_d_req_o`=0 and both `gnt`=0.
  - Then assert `rvalid` once: a new accept occurs in the same cycle as the pop; the count stays 2.
- **Mixed owners in flight.**
  - Stimulus: queue m1 then m0 with delayed responses returning data 0x11 then 0x22.
  - Required: `m1_rvalid_o` with 0x11 first, then `m0_rvalid_o` with 0x22.
- **Stray response.**
  - Stimulus: `sram_d_rvalid_i`=1 with an empty FIFO.
  - Required: `resp_orphan_o`=1 for one cycle; both `rvalid` outputs stay 0.
- **Reset mid-operation.**
  - Stimulus: assert `rst_i` asynchronously between clock edges with 2 outstanding.
  - Required: count 0 immediately; the subsequent `rvalid` is treated as orphaned; the first tie after reset goes to m0.
